// File: rtl/ram_portb_arbiter.sv
// rtl/ram_portb_arbiter.sv - port-B arbiter/sequencer for the data RAM (display vs UART loader)
module ram_portb_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2048,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_err,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_b,
    output logic              ram_wren_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_LOAD} owner_t;

    localparam logic [7:0]      MAX_W   = 8'(MAX_WAIT);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [7:0]        starve_cnt;
    owner_t            rd_owner;
    owner_t            owner_d;
    logic              oor;
    logic              ld_in_range;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] disp_rdata_q;
    logic [DATA_W-1:0] ld_rdata_q;

    assign ld_in_range = ({1'b0, ld_addr} < DEPTH_L);

    // Fixed priority to the display unless the loader has waited MAX_WAIT cycles; no grants in reset
    always_comb begin
        disp_gnt = 1'b0;
        ld_gnt   = 1'b0;
        if (!rst) begin
            if (ld_req && (!disp_req || starve_cnt == MAX_W))
                ld_gnt = 1'b1;
            else if (disp_req)
                disp_gnt = 1'b1;
        end
    end

    // Port mux; when idle the address holds the last driven value
    always_comb begin
        ram_addr_b = addr_q;
        ram_data_b = ld_wdata;
        ram_wren_b = 1'b0;
        owner_d    = OWN_NONE;
        if (ld_gnt) begin
            ram_addr_b = ld_addr;
            ram_wren_b = ld_we && ld_in_range;
            if (!ld_we)
                owner_d = OWN_LOAD;
        end else if (disp_gnt) begin
            ram_addr_b = disp_addr;
            owner_d    = OWN_DISP;
        end
    end

    // Read return routing: one cycle after the grant, to whoever issued the read
    always_comb begin
        disp_rvalid = (rd_owner == OWN_DISP);
        ld_rvalid   = (rd_owner == OWN_LOAD);
        disp_rdata  = disp_rvalid ? ram_q_b : disp_rdata_q;
        if (ld_rvalid)
            ld_rdata = oor ? {DATA_W{1'b1}} : ram_q_b;
        else
            ld_rdata = ld_rdata_q;
    end

    // State: address mirror, starvation counter, read owner, held read data, sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            starve_cnt   <= '0;
            rd_owner     <= OWN_NONE;
            oor          <= 1'b0;
            ld_err       <= 1'b0;
            disp_rdata_q <= '0;
            ld_rdata_q   <= '0;
        end else begin
            if (disp_gnt || ld_gnt)
                addr_q <= ram_addr_b;
            if (ld_req && !ld_gnt)
                starve_cnt <= (starve_cnt == MAX_W) ? starve_cnt : starve_cnt + 8'd1;
            else
                starve_cnt <= '0;
            rd_owner <= owner_d;
            oor      <= ld_gnt && !ld_in_range;
            if (ld_gnt && !ld_in_range)
                ld_err <= 1'b1;
            if (disp_rvalid)
                disp_rdata_q <= disp_rdata;
            if (ld_rvalid)
                ld_rdata_q <= ld_rdata;
        end
    end

endmodule

// File: tb/tb_ram_portb_arbiter.sv
// tb/tb_ram_portb_arbiter.sv - directed self-checking bench for ram_portb_arbiter
module tb_ram_portb_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic              disp_gnt, disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              ld_req = 1'b0, ld_we = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_wdata = '0;
    logic              ld_gnt, ld_rvalid, ld_err;
    logic [DATA_W-1:0] ld_rdata;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_data_b;
    logic              ram_wren_b;
    logic [DATA_W-1:0] ram_q_b = '0;

    logic [DATA_W-1:0] mem [0:2047];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    ram_portb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(1024), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_wren_b(ram_wren_b),
        .ram_q_b(ram_q_b)
    );

    always #5 clk = ~clk;

    // Registered-output RAM model (2048 words) with a bench-side preload port
    always @(posedge clk) begin
        if (ram_wren_b)
            mem[ram_addr_b] <= ram_data_b;
        else if (pre_we)
            mem[pre_addr] <= pre_data;
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        next_cycle();
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        disp_req = 1'b1; disp_addr = 11'd9;
        preload(11'd1, 32'h0000_0011);
        preload(11'd2, 32'h0000_0022);
        preload(11'd3, 32'h0000_0033);
        preload(11'd5, 32'h0000_0003);
        preload(11'd7, 32'h0000_0077);
        preload(11'd1500, 32'h0000_1234);
        @(negedge clk);
        n_tests++; if (disp_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_disp_gnt got %0h want 0", disp_gnt); end
        n_tests++; if (ld_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_ld_gnt got %0h want 0", ld_gnt); end
        n_tests++; if (disp_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %0b%0b want 00", disp_rvalid, ld_rvalid); end
        n_tests++; if (disp_rdata !== 32'h0 || ld_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h/%h want 0/0", disp_rdata, ld_rdata); end
        n_tests++; if (ram_wren_b !== 1'b0 || ram_addr_b !== 11'd0) begin n_fail++; $display("FAIL reset_port got wren %0b addr %0d want 0/0", ram_wren_b, ram_addr_b); end
        n_tests++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL reset_ld_err got %0b want 0", ld_err); end
        disp_req = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_display_only;
        disp_req = 1'b1; disp_addr = 11'd5;
        @(negedge clk);
        n_tests++; if (disp_gnt !== 1'b1 || ld_gnt !== 1'b0) begin n_fail++; $display("FAIL disp_only_gnt got %0b%0b want 10", disp_gnt, ld_gnt); end
        n_tests++; if (ram_addr_b !== 11'd5 || ram_wren_b !== 1'b0) begin n_fail++; $display("FAIL disp_only_port got addr %0d wren %0b want 5/0", ram_addr_b, ram_wren_b); end
        next_cycle();
        disp_req = 1'b0;
        @(negedge clk);
        n_tests++; if (disp_rvalid !== 1'b1 || disp_rdata !== 32'h0000_0003) begin n_fail++; $display("FAIL disp_only_rdata got v%0b %h want v1 00000003", disp_rvalid, disp_rdata); end
        n_tests++; if (ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL disp_only_ld_rvalid got %0b want 0", ld_rvalid); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (disp_rvalid !== 1'b0 || disp_rdata !== 32'h0000_0003) begin n_fail++; $display("FAIL disp_only_hold got v%0b %h want v0 00000003", disp_rvalid, disp_rdata); end
        n_tests++; if (ram_addr_b !== 11'd5) begin n_fail++; $display("FAIL idle_addr_hold got %0d want 5", ram_addr_b); end
        next_cycle();
    endtask

    task automatic test_write_then_read;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 11'd12; ld_wdata = 32'hA5A5_0007;
        @(negedge clk);
        n_tests++; if (ld_gnt !== 1'b1 || ram_wren_b !== 1'b1 || ram_addr_b !== 11'd12 || ram_data_b !== 32'hA5A5_0007) begin
            n_fail++; $display("FAIL wr_port got gnt %0b wren %0b addr %0d data %h want 1/1/12/a5a50007", ld_gnt, ram_wren_b, ram_addr_b, ram_data_b); end
        next_cycle();
        ld_req = 1'b0; ld_we = 1'b0;
        disp_req = 1'b1; disp_addr = 11'd12;
        @(negedge clk);
        n_tests++; if (disp_gnt !== 1'b1 || ram_wren_b !== 1'b0) begin n_fail++; $display("FAIL rd_after_wr_gnt got gnt %0b wren %0b want 1/0", disp_gnt, ram_wren_b); end
        n_tests++; if (ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL write_no_rvalid got %0b want 0", ld_rvalid); end
        next_cycle();
        disp_req = 1'b0;
        @(negedge clk);
        n_tests++; if (disp_rvalid !== 1'b1 || disp_rdata !== 32'hA5A5_0007) begin n_fail++; $display("FAIL rd_after_wr_data got v%0b %h want v1 a5a50007", disp_rvalid, disp_rdata); end
        next_cycle();
    endtask

    task automatic test_starvation;
        disp_req = 1'b1; disp_addr = 11'd9;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 11'd7;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            n_tests++;
            if (ld_gnt !== ((k % 9) == 8) || disp_gnt !== ((k % 9) != 8)) begin
                n_fail++; $display("FAIL starve_cycle%0d got d%0b l%0b want d%0b l%0b", k, disp_gnt, ld_gnt, (k % 9) != 8, (k % 9) == 8);
            end
            next_cycle();
        end
        disp_req = 1'b0; ld_req = 1'b0;
        @(negedge clk);
        n_tests++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h0000_0077 || disp_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL starve_ld_data got lv%0b %h dv%0b want lv1 00000077 dv0", ld_rvalid, ld_rdata, disp_rvalid); end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        disp_req = 1'b1; disp_addr = 11'd1;
        next_cycle();
        disp_req = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 11'd2;
        @(negedge clk);
        n_tests++; if (disp_rvalid !== 1'b1 || disp_rdata !== 32'h11 || ld_rvalid !== 1'b0 || ld_gnt !== 1'b1) begin
            n_fail++; $display("FAIL b2b_1 got dv%0b %h lv%0b lg%0b want dv1 00000011 lv0 lg1", disp_rvalid, disp_rdata, ld_rvalid, ld_gnt); end
        next_cycle();
        ld_req = 1'b0; disp_req = 1'b1; disp_addr = 11'd3;
        @(negedge clk);
        n_tests++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h22 || disp_rvalid !== 1'b0 || disp_gnt !== 1'b1) begin
            n_fail++; $display("FAIL b2b_2 got lv%0b %h dv%0b dg%0b want lv1 00000022 dv0 dg1", ld_rvalid, ld_rdata, disp_rvalid, disp_gnt); end
        next_cycle();
        disp_req = 1'b0;
        @(negedge clk);
        n_tests++; if (disp_rvalid !== 1'b1 || disp_rdata !== 32'h33 || ld_rvalid !== 1'b0 || ld_rdata !== 32'h22) begin
            n_fail++; $display("FAIL b2b_3 got dv%0b %h lv%0b %h want dv1 00000033 lv0 00000022", disp_rvalid, disp_rdata, ld_rvalid, ld_rdata); end
        next_cycle();
    endtask

    task automatic test_out_of_range;
        n_tests++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pre got %0b want 0", ld_err); end
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 11'd1500; ld_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++; if (ld_gnt !== 1'b1 || ram_wren_b !== 1'b0) begin n_fail++; $display("FAIL oor_wr got gnt %0b wren %0b want 1/0", ld_gnt, ram_wren_b); end
        next_cycle();
        ld_we = 1'b0;
        @(negedge clk);
        n_tests++; if (ld_err !== 1'b1 || ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL oor_wr_err got err %0b rv %0b want 1/0", ld_err, ld_rvalid); end
        next_cycle();
        ld_addr = 11'd7;
        @(negedge clk);
        n_tests++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL oor_rd got v%0b %h want v1 ffffffff", ld_rvalid, ld_rdata); end
        next_cycle();
        ld_req = 1'b0;
        @(negedge clk);
        n_tests++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h77 || ld_err !== 1'b1) begin n_fail++; $display("FAIL oor_after got v%0b %h err %0b want v1 00000077 err1", ld_rvalid, ld_rdata, ld_err); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read;
        disp_req = 1'b1; disp_addr = 11'd5;
        @(negedge clk);
        n_tests++; if (disp_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt got %0b want 1", disp_gnt); end
        #1 rst = 1'b1;
        #1;
        n_tests++; if (disp_gnt !== 1'b0 || ram_addr_b !== 11'd0 || ld_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async got gnt %0b addr %0d err %0b want 0/0/0", disp_gnt, ram_addr_b, ld_err); end
        n_tests++; if (disp_rdata !== 32'h0 || ld_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata got %h/%h want 0/0", disp_rdata, ld_rdata); end
        next_cycle();
        disp_req = 1'b0;
        @(negedge clk);
        n_tests++; if (disp_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid_in_rst got %0b want 0", disp_rvalid); end
        rst = 1'b0;
        disp_req = 1'b1; disp_addr = 11'd1;
        #1;
        n_tests++; if (disp_rvalid !== 1'b0 || disp_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_release got rv %0b gnt %0b want 0/1", disp_rvalid, disp_gnt); end
        next_cycle();
        disp_req = 1'b0;
        @(negedge clk);
        n_tests++; if (disp_rvalid !== 1'b1 || disp_rdata !== 32'h11) begin n_fail++; $display("FAIL midrst_resume got v%0b %h want v1 00000011", disp_rvalid, disp_rdata); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_display_only();
        test_write_then_read();
        test_starvation();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
